// File: rtl/aes_round_tail_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES round helpers for the round-tail datapath.
//   AES_STATE_W : width of the AES state (128 bits)
//   xtime       : multiply a byte by 2 in GF(2^8), reduction polynomial 0x11B
//   shift_rows  : AES ShiftRows on a 128-bit state
// State byte order: data[127:120] is byte 0, bytes are column-major,
// byte k sits at row k mod 4, column k/4.
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int unsigned AES_STATE_W = 128;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      logic [7:0] shifted;
      shifted = {b[6:0], 1'b0};
      // Reduce by 0x11B when the shifted-out bit was set.
      return b[7] ? (shifted ^ 8'h1b) : shifted;
   endfunction

   // Output byte (r,c) takes input byte (r, (c+r) mod 4).
   function automatic logic [AES_STATE_W-1:0] shift_rows(input logic [AES_STATE_W-1:0] s);
      logic [AES_STATE_W-1:0] res;
      res = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            res[(AES_STATE_W-1) - 8*(r + 4*c) -: 8] =
               s[(AES_STATE_W-1) - 8*(r + 4*((c + r) % 4)) -: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/aes_round_tail_mix_column.sv
// ---------------------------------------------------------------------------
// mix_column
// Combinational AES MixColumns on one 32-bit column.
//   col   in  [31:0] : column bytes, col[31:24] is row 0
//   mixed out [31:0] : column multiplied by [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]
// ---------------------------------------------------------------------------
module mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col,
   output logic [31:0] mixed
);

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] x0, x1, x2, x3;

   always_comb begin
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      x0 = xtime(a0);
      x1 = xtime(a1);
      x2 = xtime(a2);
      x3 = xtime(a3);
      // 3*a is expressed as xtime(a) ^ a.
      mixed[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
      mixed[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
      mixed[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
      mixed[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
   end

endmodule

// File: rtl/aes_round_tail.sv
// ---------------------------------------------------------------------------
// aes_round_tail
// Finishes one AES-256 encryption round after SubBytes: ShiftRows,
// MixColumns (bypassed on the final round) and AddRoundKey, with the result
// registered behind a valid/ready handshake.
//
// Ports:
//   clk       in        : rising-edge clock
//   rst_n     in        : synchronous reset, active-low
//   in_valid  in        : in_data / in_key / in_last are valid
//   in_ready  out       : block accepts input this cycle
//   in_data   in  [127] : SubBytes output state
//   in_key    in  [127] : round key
//   in_last   in        : final round, MixColumns bypassed
//   out_valid out       : out_data holds a completed round
//   out_ready in        : consumer takes out_data
//   out_data  out [127] : round output state
//   out_last  out       : in_last carried with the data
//
// Configuration macro AES_ROUND_TAIL_SKID_EN:
//   defined     : one-entry skid register, in_ready registered (= !skid_full)
//   not defined : single output register, in_ready = !out_valid || out_ready
// ---------------------------------------------------------------------------
module aes_round_tail
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_data,
   input  logic [AES_STATE_W-1:0] in_key,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_data,
   output logic                   out_last
);

   logic [AES_STATE_W-1:0] sr_state;
   logic [AES_STATE_W-1:0] mc_state;
   logic [AES_STATE_W-1:0] round_state;
   logic                   accept;
   logic                   out_free;

   // ---------------------------------------------------------------
   // Combinational round datapath
   // ---------------------------------------------------------------
   always_comb sr_state = shift_rows(in_data);

   for (genvar c = 0; c < 4; c++) begin : g_col
      mix_column u_mix_column (
         .col   (sr_state[(AES_STATE_W-1) - 32*c -: 32]),
         .mixed (mc_state[(AES_STATE_W-1) - 32*c -: 32])
      );
   end

   always_comb round_state = (in_last ? sr_state : mc_state) ^ in_key;

   // Output register can take new data: empty, or emptying this cycle.
   always_comb out_free = !out_valid || out_ready;

`ifdef AES_ROUND_TAIL_SKID_EN
   // ---------------------------------------------------------------
   // Output register plus one-entry skid register
   // ---------------------------------------------------------------
   logic                   skid_full;
   logic [AES_STATE_W-1:0] skid_data;
   logic                   skid_last;
   logic                   in_ready_q;

   always_comb in_ready = in_ready_q;
   always_comb accept   = in_valid && in_ready_q;

   // in_ready_q tracks !skid_full as a register, so out_ready never reaches
   // in_ready combinationally. While the skid holds data no input is
   // accepted, so draining the skid and accepting never coincide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         skid_full  <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (out_free) begin
         if (skid_full) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            out_last   <= skid_last;
            skid_full  <= 1'b0;
            in_ready_q <= 1'b1;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= round_state;
            out_last  <= in_last;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         // Output stalled: park the new result in the skid register.
         skid_full  <= 1'b1;
         skid_data  <= round_state;
         skid_last  <= in_last;
         in_ready_q <= 1'b0;
      end
   end
`else
   // ---------------------------------------------------------------
   // Single output register
   // ---------------------------------------------------------------
   always_comb in_ready = out_free;
   always_comb accept   = in_valid && out_free;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (out_free) begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= round_state;
            out_last  <= in_last;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
`endif

endmodule
